// File: rtl/frame_lane_router_if.sv
// Symbol stream bundle between the upstream source, the frame router and the lane demux.
// Latency: none, this only groups the wires.
// Backpressure: s_ready / m_ready valid-ready handshakes on the two streams.
//
// Ports (signals):
//   s_data/s_sof/s_valid -> router, s_ready <- router  (upstream symbol stream)
//   m_data/m_sel/m_valid/m_last <- router, m_ready -> router  (payload to demux)
// Modports: slave = the router side, master = the environment side.
interface frame_lane_router_if #(
  parameter int DATA_W = 5,
  parameter int LANE_W = 2
);
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic [LANE_W-1:0] m_sel;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  modport slave (
    input  s_data, s_sof, s_valid, m_ready,
    output s_ready, m_data, m_sel, m_valid, m_last
  );

  modport master (
    output s_data, s_sof, s_valid, m_ready,
    input  s_ready, m_data, m_sel, m_valid, m_last
  );
endinterface

// File: rtl/frame_lane_router.sv
// Frame router: parses header symbols (lane, length) and forwards payload with a stable lane select.
// Latency: payload accepted at cycle N appears on m_* at cycle N+1; headers produce no beat.
// Backpressure: 1-entry output register, s_ready = ~m_valid | m_ready.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   bus          frame_lane_router_if.slave (input symbol stream in, payload stream out)
//   busy         high while a frame payload is being collected
//   frame_err    one-cycle pulse on a stray payload symbol or an early header
//   frames_done  saturating count of frames delivered with their full payload
//   err_count    saturating count of framing errors
module frame_lane_router #(
  parameter int DATA_W = 5,
  parameter int LANE_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_lane_router_if.slave   bus,
  output logic                 busy,
  output logic                 frame_err,
  output logic [CNT_W-1:0]     frames_done,
  output logic [CNT_W-1:0]     err_count
);

  localparam int LEN_W = 3;
  localparam int REM_W = LEN_W + 1;  // holds 1..8

  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t             state_q, state_nxt;
  logic [LANE_W-1:0]  lane_q, lane_nxt;
  logic [REM_W-1:0]   rem_q, rem_nxt;

  logic               xfer_in;
  logic               load;
  logic               load_last;
  logic               err_evt;
  logic               done_evt;
  logic [LANE_W-1:0]  hdr_lane;
  logic [REM_W-1:0]   hdr_len;

  assign bus.s_ready = ~bus.m_valid | bus.m_ready;
  assign xfer_in     = bus.s_valid & bus.s_ready;
  assign hdr_lane    = bus.s_data[LANE_W-1:0];
  assign hdr_len     = {1'b0, bus.s_data[LANE_W +: LEN_W]} + REM_W'(1);
  assign busy        = (state_q == PAYLOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_nxt;
      lane_q  <= lane_nxt;
      rem_q   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    lane_nxt  = lane_q;
    rem_nxt   = rem_q;
    load      = 1'b0;
    load_last = 1'b0;
    err_evt   = 1'b0;
    done_evt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer_in) begin
          if (bus.s_sof) begin
            lane_nxt  = hdr_lane;
            rem_nxt   = hdr_len;
            state_nxt = PAYLOAD;
          end else begin
            err_evt = 1'b1;  // payload with no open frame is dropped
          end
        end
      end
      PAYLOAD: begin
        if (xfer_in) begin
          if (bus.s_sof) begin
            // Early header: abandon the open frame without an m_last and
            // restart on the new header in the same cycle.
            err_evt  = 1'b1;
            lane_nxt = hdr_lane;
            rem_nxt  = hdr_len;
          end else begin
            load    = 1'b1;
            rem_nxt = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) begin
              load_last = 1'b1;
              done_evt  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: m_sel is taken from the latched lane, so it can only
  // change when a new beat is loaded, never while a beat is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_sel   <= '0;
      bus.m_last  <= 1'b0;
    end else if (load) begin
      bus.m_valid <= 1'b1;
      bus.m_data  <= bus.s_data;
      bus.m_sel   <= lane_q;
      bus.m_last  <= load_last;
    end else if (bus.m_valid && bus.m_ready) begin
      bus.m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err   <= 1'b0;
      frames_done <= '0;
      err_count   <= '0;
    end else begin
      frame_err <= err_evt;
      if (done_evt && (frames_done != '1)) frames_done <= frames_done + CNT_W'(1);
      if (err_evt && (err_count != '1))    err_count   <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_frame_lane_router.sv
module tb_frame_lane_router;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       frame_err;
  logic [7:0] frames_done;
  logic [7:0] err_count;

  frame_lane_router_if #(.DATA_W(5), .LANE_W(2)) bus ();

  frame_lane_router #(.DATA_W(5), .LANE_W(2), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .frame_err   (frame_err),
    .frames_done (frames_done),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected beat: {last, sel[1:0], data[4:0]}
  logic [7:0] sb[$];

  // Scoreboard monitor: every completed output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      logic [7:0] got;
      logic [7:0] exp;
      got = {bus.m_last, bus.m_sel, bus.m_data};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got last=%0b sel=%0d data=%0d, required no beat",
                 got[7], got[6:5], got[4:0]);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL beat: got last=%0b sel=%0d data=%0d, required last=%0b sel=%0d data=%0d",
                   got[7], got[6:5], got[4:0], exp[7], exp[6:5], exp[4:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one symbol until accepted; returns #1 after the accepting edge.
  task automatic send(input logic sof, input logic [4:0] d);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_sof   = sof;
    bus.s_data  = d;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic pay(input logic [4:0] d, input logic [1:0] sel, input logic last);
    sb.push_back({last, sel, d});
    send(1'b0, d);
  endtask

  task automatic check_drained(input string name);
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    #7;
    total++;
    if ({bus.m_valid, bus.m_last, bus.m_sel, bus.m_data, busy, frame_err} !== 11'd0
        || frames_done !== 8'd0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: m_valid=%0b m_last=%0b m_sel=%0d m_data=%0d busy=%0b err=%0b fd=%0d ec=%0d, required all 0",
               bus.m_valid, bus.m_last, bus.m_sel, bus.m_data, busy, frame_err, frames_done, err_count);
    end
    total++;
    if (bus.s_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_s_ready: got %0b, required 1", bus.s_ready);
    end
    apply_reset();
  endtask

  task automatic test_basic_frame();
    apply_reset();
    send(1'b1, 5'b011_10);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy: got %0b, required 1", busy);
    end
    for (int i = 1; i <= 4; i++) pay(5'(i), 2'd2, i == 4);
    total++;
    if (frames_done !== 8'd1) begin
      bad++;
      $display("FAIL basic_frames_done: got %0d, required 1", frames_done);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: busy=%0b, required 0", busy);
    end
    check_drained("basic");
  endtask

  task automatic test_stall();
    apply_reset();
    send(1'b1, 5'b011_10);
    pay(5'd1, 2'd2, 1'b0);
    pay(5'd2, 2'd2, 1'b0);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_sof   = 1'b0;
    bus.s_data  = 5'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== 5'd2 || bus.m_sel !== 2'd2) begin
        bad++;
        $display("FAIL stall_hold: s_ready=%0b m_valid=%0b m_data=%0d m_sel=%0d, required 0 1 2 2",
                 bus.s_ready, bus.m_valid, bus.m_data, bus.m_sel);
      end
    end
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    pay(5'd3, 2'd2, 1'b0);
    pay(5'd4, 2'd2, 1'b1);
    check_drained("stall");
    total++;
    if (frames_done !== 8'd1) begin
      bad++;
      $display("FAIL stall_frames_done: got %0d, required 1", frames_done);
    end
  endtask

  task automatic test_idle_error();
    apply_reset();
    send(1'b0, 5'd7);
    total++;
    if (frame_err !== 1'b1 || err_count !== 8'd1) begin
      bad++;
      $display("FAIL idle_err: frame_err=%0b err_count=%0d, required 1 1", frame_err, err_count);
    end
    @(posedge clk);
    #1;
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL idle_err_pulse: frame_err=%0b, required 0", frame_err);
    end
    check_drained("idle_err");
  endtask

  task automatic test_early_header();
    apply_reset();
    send(1'b1, 5'b011_01);
    pay(5'd1, 2'd1, 1'b0);
    pay(5'd2, 2'd1, 1'b0);
    send(1'b1, 5'b000_11);
    total++;
    if (frame_err !== 1'b1 || err_count !== 8'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL early_hdr: frame_err=%0b err_count=%0d busy=%0b, required 1 1 1",
               frame_err, err_count, busy);
    end
    pay(5'd9, 2'd3, 1'b1);
    total++;
    if (frames_done !== 8'd1) begin
      bad++;
      $display("FAIL early_frames_done: got %0d, required 1", frames_done);
    end
    check_drained("early_hdr");
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    send(1'b1, 5'b011_00);
    bus.m_ready = 1'b0;
    send(1'b0, 5'd5);  // deliberately not expected: reset discards it
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midreset: m_valid=%0b busy=%0b, required 0 0", bus.m_valid, busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.m_ready = 1'b1;
    send(1'b1, 5'b000_01);
    pay(5'd6, 2'd1, 1'b1);
    check_drained("midreset");
    total++;
    if (frames_done !== 8'd1 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL midreset_counts: fd=%0d ec=%0d, required 1 0", frames_done, err_count);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send(1'b1, 5'b111_10);
    for (int i = 0; i < 8; i++) pay(5'(20 + i), 2'd2, i == 7);
    send(1'b1, 5'b001_01);
    pay(5'd30, 2'd1, 1'b0);
    pay(5'd31, 2'd1, 1'b1);
    check_drained("b2b");
    total++;
    if (frames_done !== 8'd2) begin
      bad++;
      $display("FAIL b2b_frames_done: got %0d, required 2", frames_done);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      send(1'b1, 5'b000_00);
      pay(5'(k), 2'd0, 1'b1);
    end
    check_drained("sat");
    total++;
    if (frames_done !== 8'd255 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL sat_counts: fd=%0d ec=%0d, required 255 0", frames_done, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_idle_error();
    test_early_header();
    test_reset_midframe();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
